// File: rtl/onehot_filter_pkg.sv
// Shared types and constants for the one-hot decoder post-processor.
// FSM encodings and code/index widths used by onehot_filter and its bench.
package onehot_filter_pkg;

    localparam int unsigned CODE_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } state_e;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [IDX_W-1:0]  idx_t;

endpackage

// File: rtl/onehot_filter_sync_2ff.sv
// Parameterised-width two-flop synchroniser with async active-low reset.
// Shared with other labs; keep the interface generic.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/onehot_filter.sv
// Deglitches the lab 3-to-8 decoder output, latches the last valid one-hot
// pattern for the LEDs, flags non-one-hot codes and counts pattern changes.
module onehot_filter
    import onehot_filter_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [CODE_W-1:0] in_code,
    output logic [CODE_W-1:0] led_out,
    output logic [IDX_W-1:0]  idx,
    output logic              valid,
    output logic              err,
    output logic              change_pulse,
    output logic [CNT_W-1:0]  change_cnt
);

    localparam int unsigned       STAB_W    = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CNT - 1);

    function automatic logic is_onehot(input code_t c);
        return (c != '0) && ((c & (c - code_t'(1))) == '0);
    endfunction

    // OR-reduction encoder; only meaningful for one-hot inputs.
    function automatic idx_t encode(input code_t c);
        idx_t r;
        r = '0;
        for (int i = 0; i < CODE_W; i++) begin
            if (c[i]) r = r | IDX_W'(i);
        end
        return r;
    endfunction

    code_t             sync_code;
    code_t             cand;
    code_t             cand_nxt;
    logic [STAB_W-1:0] stab_cnt;
    logic [STAB_W-1:0] stab_nxt;
    state_e            state;
    state_e            state_nxt;
    logic              commit_c;
    logic              onehot_c;
    logic              new_pat_c;

    sync_2ff #(
        .W(CODE_W)
    ) u_sync (
        .clk  (sys_clk),
        .rst_n(sys_rst_n),
        .d    (in_code),
        .q    (sync_code)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= SETTLE;
            cand     <= '0;
            stab_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cand     <= cand_nxt;
            stab_cnt <= stab_nxt;
        end
    end

    // Any change of the synchronised code reloads the candidate and restarts the window.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        stab_nxt  = stab_cnt;
        commit_c  = 1'b0;
        case (state)
            SETTLE: begin
                if (sync_code != cand) begin
                    cand_nxt = sync_code;
                    stab_nxt = '0;
                end else if (stab_cnt == STAB_LAST) begin
                    commit_c  = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    stab_nxt = stab_cnt + STAB_W'(1);
                end
            end
            HOLD: begin
                if (sync_code != cand) begin
                    cand_nxt  = sync_code;
                    stab_nxt  = '0;
                    state_nxt = SETTLE;
                end
            end
            default: state_nxt = SETTLE;
        endcase
    end

    assign onehot_c  = is_onehot(cand);
    assign new_pat_c = commit_c && onehot_c && (!valid || (cand != led_out));

    // Committed outputs; a recommit of the displayed pattern only clears err.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_out      <= '0;
            idx          <= '0;
            valid        <= 1'b0;
            err          <= 1'b0;
            change_pulse <= 1'b0;
            change_cnt   <= '0;
        end else begin
            change_pulse <= new_pat_c;
            if (commit_c) begin
                err <= !onehot_c;
            end
            if (new_pat_c) begin
                led_out    <= cand;
                idx        <= encode(cand);
                valid      <= 1'b1;
                change_cnt <= change_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_onehot_filter.sv
// Self-checking bench for onehot_filter: directed table, latency/reset
// sequences and randomized codes checked against a run-length reference model.
module tb_onehot_filter;

    localparam int unsigned STABLE = 16;
    localparam int unsigned CW     = 4;

    logic          clk;
    logic          rst_n;
    logic [7:0]    in_code;
    logic [7:0]    led_out;
    logic [2:0]    idx;
    logic          valid;
    logic          err;
    logic          change_pulse;
    logic [CW-1:0] change_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    onehot_filter #(
        .STABLE_CNT(STABLE),
        .CNT_W     (CW)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .in_code     (in_code),
        .led_out     (led_out),
        .idx         (idx),
        .valid       (valid),
        .err         (err),
        .change_pulse(change_pulse),
        .change_cnt  (change_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a code commits once the synchronised value has been seen
    // unchanged on STABLE+1 consecutive edges (reset counts as the first).
    logic [7:0]    h0, h1, prev_s;
    int            run;
    logic [7:0]    m_led;
    logic [2:0]    m_idx;
    logic          m_valid, m_err, m_pulse;
    logic [CW-1:0] m_cnt;

    always @(posedge clk or negedge rst_n) begin : model
        logic [7:0] s;
        int         nrun;
        if (!rst_n) begin
            h0 <= '0; h1 <= '0; prev_s <= '0; run <= 1;
            m_led <= '0; m_idx <= '0; m_valid <= 1'b0; m_err <= 1'b0;
            m_pulse <= 1'b0; m_cnt <= '0;
        end else begin
            s      = h1;
            nrun   = (s == prev_s) ? run + 1 : 1;
            h1     <= h0;
            h0     <= in_code;
            prev_s <= s;
            run    <= (nrun > 1000) ? 1000 : nrun;
            m_pulse <= 1'b0;
            if (nrun == STABLE + 1) begin
                if ($countones(s) == 1) begin
                    m_err <= 1'b0;
                    if (!m_valid || s != m_led) begin
                        m_led   <= s;
                        m_idx   <= 3'($clog2(s));
                        m_valid <= 1'b1;
                        m_pulse <= 1'b1;
                        m_cnt   <= m_cnt + 1'b1;
                    end
                end else begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_led",   32'(led_out),      32'(m_led));
            chk("mdl_idx",   32'(idx),          32'(m_idx));
            chk("mdl_valid", 32'(valid),        32'(m_valid));
            chk("mdl_err",   32'(err),          32'(m_err));
            chk("mdl_pulse", 32'(change_pulse), 32'(m_pulse));
            chk("mdl_cnt",   32'(change_cnt),   32'(m_cnt));
        end
    end

    typedef struct {
        logic [7:0] code;
        int         cycles;
        logic [7:0] led;
        logic [2:0] idx;
        logic       valid;
        logic       err;
        int         cnt;
        int         pulses;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[8];
        int         pulses;
        logic [7:0] prev, code;
        int         exp_changes;
        bit         seen_wrap;
        logic [CW-1:0] last_cnt;

        vecs[0] = '{8'h04, 20, 8'h04, 3'd2, 1'b1, 1'b0, 1, 0};
        vecs[1] = '{8'h10, 10, 8'h04, 3'd2, 1'b1, 1'b0, 1, 0};
        vecs[2] = '{8'h04, 30, 8'h04, 3'd2, 1'b1, 1'b0, 1, 0};
        vecs[3] = '{8'h06, 30, 8'h04, 3'd2, 1'b1, 1'b1, 1, 0};
        vecs[4] = '{8'h04, 30, 8'h04, 3'd2, 1'b1, 1'b0, 1, 0};
        vecs[5] = '{8'h01, 30, 8'h01, 3'd0, 1'b1, 1'b0, 2, 1};
        vecs[6] = '{8'h80, 30, 8'h80, 3'd7, 1'b1, 1'b0, 3, 1};
        vecs[7] = '{8'h00, 30, 8'h80, 3'd7, 1'b1, 1'b1, 3, 0};

        rst_n   = 1'b1;
        in_code = 8'h00;
        #1 rst_n = 1'b0;
        wait_edges(3);
        chk_en = 1'b1;
        chk("rst_led",   32'(led_out),    32'h0);
        chk("rst_valid", 32'(valid),      32'h0);
        chk("rst_err",   32'(err),        32'h0);
        chk("rst_cnt",   32'(change_cnt), 32'h0);

        // Zero held from reset: err rises exactly at edge STABLE.
        rst_n = 1'b1;
        wait_edges(STABLE - 1);
        chk("zero_err_early", 32'(err), 32'h0);
        wait_edges(1);
        chk("zero_err",   32'(err),     32'h1);
        chk("zero_valid", 32'(valid),   32'h0);
        chk("zero_led",   32'(led_out), 32'h0);
        chk("zero_cnt",   32'(change_cnt), 32'h0);

        // First commit latency: 3+STABLE edges after the change.
        in_code = 8'h04;
        wait_edges(STABLE + 2);
        chk("lat_led_early", 32'(led_out), 32'h0);
        chk("lat_valid_early", 32'(valid), 32'h0);
        wait_edges(1);
        chk("lat_led",   32'(led_out),      32'h04);
        chk("lat_idx",   32'(idx),          32'd2);
        chk("lat_valid", 32'(valid),        32'h1);
        chk("lat_err",   32'(err),          32'h0);
        chk("lat_pulse", 32'(change_pulse), 32'h1);
        chk("lat_cnt",   32'(change_cnt),   32'd1);
        wait_edges(1);
        chk("lat_pulse_drop", 32'(change_pulse), 32'h0);

        for (int i = 0; i < 8; i++) begin
            in_code = vecs[i].code;
            pulses  = 0;
            repeat (vecs[i].cycles) begin
                @(negedge clk);
                if (change_pulse) pulses++;
            end
            chk($sformatf("vec%0d_led", i),    32'(led_out),    32'(vecs[i].led));
            chk($sformatf("vec%0d_idx", i),    32'(idx),        32'(vecs[i].idx));
            chk($sformatf("vec%0d_valid", i),  32'(valid),      32'(vecs[i].valid));
            chk($sformatf("vec%0d_err", i),    32'(err),        32'(vecs[i].err));
            chk($sformatf("vec%0d_cnt", i),    32'(change_cnt), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_pulses", i), 32'(pulses),     32'(vecs[i].pulses));
        end

        // Random one-hot codes with short random glitches in between.
        prev        = 8'h80;
        exp_changes = 3;
        seen_wrap   = 1'b0;
        last_cnt    = change_cnt;
        for (int k = 0; k < 20; k++) begin
            in_code = 8'($urandom);
            repeat ($urandom_range(1, 12)) @(negedge clk);
            do code = 8'(1 << $urandom_range(0, 7)); while (code == prev);
            in_code = code;
            repeat (25) begin
                @(negedge clk);
                if (last_cnt == CW'(15) && change_cnt == CW'(0)) seen_wrap = 1'b1;
                last_cnt = change_cnt;
            end
            exp_changes++;
            prev = code;
            chk($sformatf("rnd%0d_led", k), 32'(led_out), 32'(code));
        end
        chk("rnd_cnt",  32'(change_cnt), 32'(exp_changes % 16));
        chk("rnd_wrap", 32'(seen_wrap),  32'h1);

        // Asynchronous reset in the middle of a settle window.
        in_code = 8'h20;
        wait_edges(12);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_led",   32'(led_out),      32'h0);
        chk("arst_idx",   32'(idx),          32'h0);
        chk("arst_valid", 32'(valid),        32'h0);
        chk("arst_err",   32'(err),          32'h0);
        chk("arst_pulse", 32'(change_pulse), 32'h0);
        chk("arst_cnt",   32'(change_cnt),   32'h0);
        wait_edges(3);
        rst_n = 1'b1;
        wait_edges(STABLE + 2);
        chk("post_valid_early", 32'(valid), 32'h0);
        wait_edges(1);
        chk("post_led",   32'(led_out),    32'h20);
        chk("post_idx",   32'(idx),        32'd5);
        chk("post_cnt",   32'(change_cnt), 32'd1);
        wait_edges(5);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
